// File: rtl/alu_ex_if.sv
// Bundle between the ID/EX issue side and the EX/MEM register of the EX-stage ALU.
// The master drives operands and pipeline control; the slave returns the registered result.
interface alu_ex_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic [3:0]           alu_ctrl;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic                 stall;
  logic                 flush;
  logic                 out_valid;
  logic [WIDTH-1:0]     alu_result;
  logic                 zero;
  logic                 overflow;
  logic                 illegal_op;
  logic [ERR_CNT_W-1:0] err_count;

  // Handshake: an issue is taken at a rising edge when in_valid=1 and neither
  // stall nor flush is high; out_valid then qualifies the registered result.
  modport master (
    output in_valid, alu_ctrl, src_a, src_b, stall, flush,
    input  out_valid, alu_result, zero, overflow, illegal_op, err_count
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, stall, flush,
    output out_valid, alu_result, zero, overflow, illegal_op, err_count
  );
endinterface

// File: rtl/alu_ex_stage.sv
// EX-stage ALU: combinational op table feeding the EX/MEM register, with
// flush/stall priority and a saturating counter of accepted illegal codes.
module alu_ex_stage #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_ex_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             ill;
  logic             capture;
  logic             err_sat;

  assign sum  = bus.src_a + bus.src_b;
  assign diff = bus.src_a - bus.src_b;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    case (bus.alu_ctrl)
      OP_AND: res = bus.src_a & bus.src_b;
      OP_OR:  res = bus.src_a | bus.src_b;
      OP_ADD: begin
        res = sum;
        ovf = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
              (sum[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
              (diff[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      // True signed compare, so it stays correct when a-b overflows.
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_NOR: res = ~(bus.src_a | bus.src_b);
      default: ill = 1'b1;
    endcase
  end

  assign capture = !bus.flush && !bus.stall;
  assign err_sat = (bus.err_count == {ERR_CNT_W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.alu_result <= '0;
      bus.zero       <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.illegal_op <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid  <= 1'b0;
      bus.alu_result <= '0;
      bus.zero       <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.illegal_op <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.alu_result <= res;
        bus.zero       <= (res == '0);
        bus.overflow   <= ovf;
        bus.illegal_op <= ill;
      end else begin
        bus.alu_result <= '0;
        bus.zero       <= 1'b0;
        bus.overflow   <= 1'b0;
        bus.illegal_op <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.err_count <= '0;
    end else if (capture && bus.in_valid && ill && !err_sat) begin
      bus.err_count <= bus.err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed and randomized bench for alu_ex_stage; a second instance with a
// 2-bit error counter shares the stimulus so counter saturation is exercised.
module tb_alu_ex_stage;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_ex_if #(.WIDTH(W), .ERR_CNT_W(8)) bus1 ();
  alu_ex_if #(.WIDTH(W), .ERR_CNT_W(2)) bus2 ();

  alu_ex_stage #(.WIDTH(W), .ERR_CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  alu_ex_stage #(.WIDTH(W), .ERR_CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state of the EX/MEM register and both error counters.
  logic          m_valid;
  logic [W-1:0]  m_res;
  logic          m_zero;
  logic          m_ovf;
  logic          m_ill;
  int            m_err1;
  int            m_err2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_res = '0; m_zero = 0; m_ovf = 0; m_ill = 0;
    m_err1 = 0; m_err2 = 0;
  endtask

  // Op semantics from signed/unsigned integer arithmetic on 64-bit values.
  task automatic ref_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic o, output logic il);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; o = 0; il = 0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6:  begin s = sa - sb; r = s[W-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  r = (sa < sb) ? 1 : 0;
      4'd12: r = ~(a | b);
      default: il = 1;
    endcase
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic st, input logic fl);
    bus1.in_valid = v; bus1.alu_ctrl = c; bus1.src_a = a; bus1.src_b = b;
    bus1.stall = st; bus1.flush = fl;
    bus2.in_valid = v; bus2.alu_ctrl = c; bus2.src_a = a; bus2.src_b = b;
    bus2.stall = st; bus2.flush = fl;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, bus1.out_valid, m_valid);
    check({tag, ".result"}, bus1.alu_result, m_res);
    check({tag, ".zero"}, bus1.zero, m_zero);
    check({tag, ".ovf"}, bus1.overflow, m_ovf);
    check({tag, ".illegal"}, bus1.illegal_op, m_ill);
    check({tag, ".err8"}, bus1.err_count, m_err1);
    check({tag, ".err2"}, bus2.err_count, m_err2);
    check({tag, ".result2"}, bus2.alu_result, m_res);
  endtask

  // Drive at the falling edge, let one rising edge capture, check at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [3:0] c,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic st, input logic fl);
    logic [W-1:0] r;
    logic o, il;
    drive(v, c, a, b, st, fl);
    @(posedge clk);
    ref_op(c, a, b, r, o, il);
    if (fl) begin
      m_valid = 0; m_res = '0; m_zero = 0; m_ovf = 0; m_ill = 0;
    end else if (!st) begin
      m_valid = v;
      m_res   = v ? r : '0;
      m_zero  = v && (r == '0);
      m_ovf   = v && o;
      m_ill   = v && il;
      if (v && il) begin
        if (m_err1 < 255) m_err1++;
        if (m_err2 < 3) m_err2++;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".valid"}, bus1.out_valid, 1'b0);
    check({tag, ".result"}, bus1.alu_result, '0);
    check({tag, ".zero"}, bus1.zero, 1'b0);
    check({tag, ".ovf"}, bus1.overflow, 1'b0);
    check({tag, ".illegal"}, bus1.illegal_op, 1'b0);
    check({tag, ".err8"}, bus1.err_count, 8'd0);
    check({tag, ".err2"}, bus2.err_count, 2'd0);
  endtask

  initial begin
    logic [W-1:0] special [5];
    logic [3:0]   legal [6];
    logic [W-1:0] a, b;
    logic [3:0]   c;
    special[0] = 32'h0; special[1] = 32'h1; special[2] = 32'hFFFF_FFFF;
    special[3] = 32'h7FFF_FFFF; special[4] = 32'h8000_0000;
    legal[0] = 4'd0; legal[1] = 4'd1; legal[2] = 4'd2;
    legal[3] = 4'd6; legal[4] = 4'd7; legal[5] = 4'd12;

    // Reset at start.
    reset = 1'b1;
    drive(0, 4'd0, '0, '0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_cleared("reset_init");
    reset = 1'b0;

    // Op sweep.
    step("add", 1, 4'd2, 32'd7, 32'd5, 0, 0);
    check("add_const", bus1.alu_result, 32'd12);
    step("sub_eq", 1, 4'd6, 32'd5, 32'd5, 0, 0);
    check("sub_eq_zero", bus1.zero, 1'b1);
    step("and", 1, 4'd0, 32'hF0F0, 32'hFF00, 0, 0);
    check("and_const", bus1.alu_result, 32'hF000);
    step("or", 1, 4'd1, 32'hF0F0, 32'hFF00, 0, 0);
    check("or_const", bus1.alu_result, 32'hFFF0);
    step("nor", 1, 4'd12, 32'h0, 32'h0, 0, 0);
    check("nor_const", bus1.alu_result, 32'hFFFF_FFFF);
    step("slt_neg", 1, 4'd7, 32'hFFFF_FFFF, 32'd1, 0, 0);
    check("slt_neg_const", bus1.alu_result, 32'd1);

    // Overflow boundaries.
    step("add_ovf", 1, 4'd2, 32'h7FFF_FFFF, 32'd1, 0, 0);
    check("add_ovf_flag", bus1.overflow, 1'b1);
    check("add_ovf_res", bus1.alu_result, 32'h8000_0000);
    step("sub_ovf", 1, 4'd6, 32'h8000_0000, 32'd1, 0, 0);
    check("sub_ovf_flag", bus1.overflow, 1'b1);
    check("sub_ovf_res", bus1.alu_result, 32'h7FFF_FFFF);
    step("slt_bound", 1, 4'd7, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0);
    check("slt_bound_const", bus1.alu_result, 32'd1);

    // Stall holds, flush wins over stall.
    step("cap_2", 1, 4'd2, 32'd1, 32'd1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 4'd6, $urandom, $urandom, 1, 0);
      check("stall_hold", bus1.alu_result, 32'd2);
    end
    step("stall_flush", 1, 4'd2, 32'd3, 32'd4, 1, 1);
    check("flush_valid", bus1.out_valid, 1'b0);
    check("flush_res", bus1.alu_result, 32'd0);

    // Asynchronous reset between edges while a valid result is held.
    step("pre_reset", 1, 4'd2, 32'd9, 32'd9, 0, 0);
    check("pre_reset_valid", bus1.out_valid, 1'b1);
    drive(1, 4'd15, 32'd1, 32'd2, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_cleared("reset_async");
    drive(1, 4'd2, 32'd5, 32'd6, 0, 0);
    @(posedge clk);
    #1 check_cleared("reset_held_edge");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Illegal code accounting and saturation of the 2-bit counter.
    step("illegal", 1, 4'hF, 32'd3, 32'd4, 0, 0);
    check("illegal_flag", bus1.illegal_op, 1'b1);
    check("illegal_err", bus1.err_count, 8'd1);
    step("illegal_bubble", 0, 4'hF, 32'd3, 32'd4, 0, 0);
    check("illegal_bubble_err", bus1.err_count, 8'd1);
    for (int i = 0; i < 4; i++) step("illegal_more", 1, 4'hF, $urandom, $urandom, 0, 0);
    check("err2_sat", bus2.err_count, 2'd3);
    check("err8_five", bus1.err_count, 8'd5);
    step("illegal_stall", 1, 4'hF, 32'd0, 32'd0, 1, 0);
    step("illegal_flush", 1, 4'hF, 32'd0, 32'd0, 0, 1);
    check("illegal_no_inc", bus1.err_count, 8'd5);

    // Bubble forces zero low.
    step("bubble", 0, 4'd6, 32'd3, 32'd3, 0, 0);
    check("bubble_zero", bus1.zero, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 7) < 6) ? legal[$urandom_range(0, 5)] : 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      step("rand", ($urandom_range(0, 4) != 0), c, a, b,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
